// File: rtl/tpu_layer_sched_if.sv
// Handshake bundle between the layer sequencer, the top-level controller and the layer engines.
// The master side drives start and the engine done/overflow lines; the slave side is the sequencer.
interface tpu_layer_sched_if #(
  parameter int unsigned NUM_LAYERS = 3
);
  logic                  start;
  logic [NUM_LAYERS-1:0] layer_done;
  logic [NUM_LAYERS-1:0] layer_overflow;
  logic [NUM_LAYERS-1:0] layer_ena;
  logic [NUM_LAYERS-1:0] layer_rst_n;
  logic [1:0]            sel;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic                  timeout;
  logic [15:0]           cycles;

  modport master (
    output start, layer_done, layer_overflow,
    input  layer_ena, layer_rst_n, sel, busy, done, overflow, timeout, cycles
  );

  modport slave (
    input  start, layer_done, layer_overflow,
    output layer_ena, layer_rst_n, sel, busy, done, overflow, timeout, cycles
  );
endinterface

// File: rtl/tpu_layer_sched.sv
// Sequences the TPU layer engines over the shared MultAdd/memory bus: launch, local reset,
// wait for a rising done, one-cycle bus bubble, with a per-layer watchdog and run statistics.
module tpu_layer_sched #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                clk,
  input  logic                iRst_n,
  tpu_layer_sched_if.slave    bus
);
  localparam int unsigned NL    = NUM_LAYERS;
  localparam int unsigned WD_W  = 12;
  localparam int unsigned CYC_W = 16;
  localparam logic [1:0]      LAST_SEL = 2'(NUM_LAYERS - 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_NEXT   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       r_state,  w_state_nxt;
  logic [1:0]       r_sel,    w_sel_nxt;
  logic [NL-1:0]    r_ena,    w_ena_nxt;
  logic [NL-1:0]    r_rst_n,  w_rst_n_nxt;
  logic             r_busy,   w_busy_nxt;
  logic             r_done,   w_done_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic             r_to,     w_to_nxt;
  logic [CYC_W-1:0] r_cycles, w_cycles_nxt;
  logic [WD_W-1:0]  r_wdog,   w_wdog_nxt;
  logic             r_dprev,  w_dprev_nxt;
  logic [NL-1:0]    w_onehot;
  logic             w_sel_done;
  logic             w_sel_ovf;

  assign w_sel_done = bus.layer_done[r_sel];
  assign w_sel_ovf  = bus.layer_overflow[r_sel];

  // State and registered outputs
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_ena    <= '0;
      r_rst_n  <= '1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_to     <= 1'b0;
      r_cycles <= '0;
      r_wdog   <= '0;
      r_dprev  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_ena    <= w_ena_nxt;
      r_rst_n  <= w_rst_n_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
      r_to     <= w_to_nxt;
      r_cycles <= w_cycles_nxt;
      r_wdog   <= w_wdog_nxt;
      r_dprev  <= w_dprev_nxt;
    end
  end

  // Next state; engine strobes are derived from the next state so they line up with it
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_ena_nxt    = '0;
    w_rst_n_nxt  = '1;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_ovf_nxt    = r_ovf;
    w_to_nxt     = r_to;
    w_cycles_nxt = r_cycles;
    w_wdog_nxt   = r_wdog;
    w_dprev_nxt  = r_dprev;
    w_onehot     = '0;

    if (r_state != S_IDLE && r_cycles != '1) begin
      w_cycles_nxt = r_cycles + CYC_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_ovf_nxt    = 1'b0;
          w_to_nxt     = 1'b0;
          w_cycles_nxt = '0;
          w_sel_nxt    = '0;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        // Preload the edge register so a done left high across the local reset is not a completion
        w_wdog_nxt  = '0;
        w_dprev_nxt = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_wdog_nxt  = r_wdog + WD_W'(1);
        w_dprev_nxt = w_sel_done;
        if (w_sel_done && !r_dprev) begin
          w_state_nxt = S_NEXT;
        end else if (r_wdog == WD_LIMIT) begin
          w_to_nxt    = 1'b1;
          w_state_nxt = S_FINISH;
        end
      end
      S_NEXT: begin
        w_ovf_nxt = r_ovf | w_sel_ovf;
        if (r_sel == LAST_SEL) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_sel_nxt   = r_sel + 2'd1;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_FINISH: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_onehot = NL'(1) << w_sel_nxt;
    if (w_state_nxt == S_LAUNCH) begin
      w_ena_nxt   = w_onehot;
      w_rst_n_nxt = ~w_onehot;
    end else if (w_state_nxt == S_RUN) begin
      w_ena_nxt = w_onehot;
    end
    w_done_nxt = (w_state_nxt == S_FINISH);
  end

  assign bus.layer_ena   = r_ena;
  assign bus.layer_rst_n = r_rst_n;
  assign bus.sel         = r_sel;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.overflow    = r_ovf;
  assign bus.timeout     = r_to;
  assign bus.cycles      = r_cycles;
endmodule
